// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drainer for an asynchronous FIFO. Pops words through the FIFO's
// rden/rdata/rempty port and presents them as a valid/ready stream. The FIFO
// read data arrives one cycle after rden, so a 2-entry skid buffer absorbs
// that latency and sustains one word per cycle while data is available and
// the consumer is ready.
//
// Ports
//   rclk      in   read-domain clock, all logic on the rising edge
//   rrst_n    in   asynchronous active-low reset
//   rempty    in   FIFO empty flag
//   rden      out  FIFO read enable, one pop per cycle high
//   rdata     in   FIFO read data, valid the cycle after rden
//   m_valid   out  stream word available
//   m_data    out  stream word (buffer head)
//   m_ready   in   consumer accepts when m_valid & m_ready
//   beat_cnt  out  accepted-beat counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              rempty,
    output logic              rden,
    input  logic [DATA_W-1:0] rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  beat_cnt
);

    // Control state
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Data buffer: never reset, contents are don't-care while occ_q is 0
    logic [DATA_W-1:0] buf_q [2];

    logic       deq;
    logic [2:0] pending;

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf_q[head_q];
    assign beat_cnt = beat_cnt_q;
    assign deq      = m_valid & m_ready;

    // Words that will still be held after this edge if no new pop is issued.
    // deq implies occ_q >= 1, so the subtraction cannot underflow.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deq};

    // Issue a pop only if the word it returns is guaranteed a buffer slot.
    // rrst_n is folded in so nothing is popped while held in reset.
    assign rden = rrst_n & ~rempty & (pending <= 3'd1);

    always_comb begin
        occ_d      = occ_q;
        inflight_d = rden;
        head_d     = head_q;
        tail_d     = tail_q;
        beat_cnt_d = beat_cnt_q;

        // Capture and dequeue in the same cycle leave occupancy unchanged.
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, deq};

        if (inflight_q) begin
            tail_d = ~tail_q;
        end
        if (deq) begin
            head_d     = ~head_q;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // The capture slot (tail) never aliases the head being read while full:
    // a capture at occ_q == 2 cannot happen because rden was gated earlier.
    // inflight_q is cleared by reset, so no capture occurs during reset.
    always_ff @(posedge rclk) begin
        if (inflight_q) begin
            buf_q[tail_q] <= rdata;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Bench for fifo_rd_stream. A behavioural FIFO model answers rden with data
// one cycle later; words loaded into the FIFO are also pushed into an
// expected queue that a monitor pops whenever a beat is accepted.
// CNT_W is set to 4 so the beat counter wrap is reachable quickly.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              rclk   = 1'b0;
    logic              rrst_n = 1'b1;
    logic              rempty = 1'b1;
    logic              rden;
    logic [DATA_W-1:0] rdata  = '0;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready = 1'b0;
    logic [CNT_W-1:0]  beat_cnt;

    fifo_rd_stream #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rempty   (rempty),
        .rden     (rden),
        .rdata    (rdata),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .beat_cnt (beat_cnt)
    );

    always #5 rclk = ~rclk;

    logic [DATA_W-1:0] fifo_q [$];
    logic [DATA_W-1:0] exp_q  [$];
    logic [CNT_W-1:0]  exp_cnt = '0;
    logic [DATA_W-1:0] exp_word;
    logic              rden_s  = 1'b0;
    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_rden   = 0;
    int                n_valid  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // FIFO model: a pop requested in a cycle returns its word the next cycle.
    always @(posedge rclk) begin
        #1;
        if (rden_s) begin
            if (fifo_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fifo_underflow: got pop on empty FIFO expected no pop");
                rdata = $urandom;
            end else begin
                rdata = fifo_q.pop_front();
            end
        end else begin
            rdata = $urandom;
        end
        rempty = (fifo_q.size() == 0);
    end

    // Monitor: sample mid-cycle, check beats against the expected queue.
    always @(negedge rclk) begin
        rden_s = rden;
        if (rempty) begin
            check("rden_while_empty", 32'(rden), 32'd0);
        end
        if (rrst_n) begin
            n_rden  += int'(rden);
            n_valid += int'(m_valid);
            check("beat_cnt_track", 32'(beat_cnt), 32'(exp_cnt));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected no beat", m_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("beat_data", m_data, exp_word);
                    $display("beat data=%h cnt=%0d", m_data, beat_cnt);
                end
                exp_cnt = exp_cnt + CNT_W'(1);
            end
        end
    end

    task automatic load(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        rempty = 1'b0;
    endtask

    task automatic sample();
        @(negedge rclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge rclk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b0;
        rrst_n  = 1'b0;
        exp_cnt = '0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rden", 32'(rden), 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        repeat (2) @(posedge rclk);
        #2;
        rrst_n = 1'b1;
    endtask

    int  run, max_run;
    logic [CNT_W-1:0] prev_cnt;
    logic saw_wrap, saw_one;

    initial begin
        #1 rrst_n = 1'b0;

        // Single word: valid two cycles after rempty falls, for one cycle.
        do_reset();
        n_rden = 0; n_valid = 0;
        load(32'hA5A5_0001);
        m_ready = 1'b1;
        sample();
        check("sw_c0_rden", 32'(rden), 32'd1);
        check("sw_c0_valid", 32'(m_valid), 32'd0);
        sample();
        check("sw_c1_rden", 32'(rden), 32'd0);
        check("sw_c1_valid", 32'(m_valid), 32'd0);
        sample();
        check("sw_c2_valid", 32'(m_valid), 32'd1);
        check("sw_c2_data", m_data, 32'hA5A5_0001);
        sample();
        check("sw_c3_valid", 32'(m_valid), 32'd0);
        check("sw_beat_cnt", 32'(beat_cnt), 32'd1);
        repeat (3) sample();
        check("sw_rden_pulses", 32'(n_rden), 32'd1);
        check("sw_valid_cycles", 32'(n_valid), 32'd1);

        // Streaming: 8 words, no bubbles.
        do_reset();
        n_rden = 0; n_valid = 0;
        for (int i = 0; i < 8; i++) load(32'(i));
        m_ready = 1'b1;
        run = 0; max_run = 0;
        repeat (14) begin
            sample();
            run = m_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check("st_max_run", 32'(max_run), 32'd8);
        check("st_rden_cycles", 32'(n_rden), 32'd8);
        check("st_valid_cycles", 32'(n_valid), 32'd8);
        check("st_beat_cnt", 32'(beat_cnt), 32'd8);

        // Backpressure: stall 10 cycles, then release.
        do_reset();
        n_rden = 0;
        for (int i = 0; i < 5; i++) load(32'hB000_0000 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            sample();
            if (i >= 2) begin
                check("bp_stall_valid", 32'(m_valid), 32'd1);
                check("bp_stall_data", m_data, 32'hB000_0000);
            end
        end
        check("bp_stall_pops", 32'(n_rden), 32'd2);
        @(posedge rclk);
        #2;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("bp_release_valid", 32'(m_valid), 32'd1);
        end
        sample();
        check("bp_drained_valid", 32'(m_valid), 32'd0);
        check("bp_beat_cnt", 32'(beat_cnt), 32'd5);

        // Empty guard: random ready, FIFO empties and refills mid-stream.
        do_reset();
        for (int i = 0; i < 6; i++) load(32'hC000_0000 + 32'(i));
        for (int i = 0; i < 30; i++) begin
            @(posedge rclk);
            #2;
            m_ready = 1'($urandom_range(0, 1));
            if (i == 12) begin
                for (int j = 6; j < 9; j++) load(32'hC000_0000 + 32'(j));
            end
        end
        @(posedge rclk);
        #2;
        m_ready = 1'b1;
        repeat (20) sample();
        check("eg_all_delivered", 32'(exp_q.size()), 32'd0);
        check("eg_beat_cnt", 32'(beat_cnt), 32'd9);

        // Reset mid-stream: D1 buffered and D2 in flight are lost.
        do_reset();
        for (int i = 0; i < 6; i++) load(32'hD000_0000 + 32'(i));
        m_ready = 1'b1;
        repeat (3) sample();
        check("rm_c2_data", m_data, 32'hD000_0000);
        @(posedge rclk);
        #2;
        check("rm_pre_valid", 32'(m_valid), 32'd1);
        rrst_n  = 1'b0;
        exp_cnt = '0;
        #1;
        check("rm_m_valid", 32'(m_valid), 32'd0);
        check("rm_rden", 32'(rden), 32'd0);
        check("rm_beat_cnt", 32'(beat_cnt), 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        repeat (2) @(posedge rclk);
        #2;
        rrst_n = 1'b1;
        repeat (10) sample();
        check("rm_remaining", 32'(exp_q.size()), 32'd0);
        check("rm_beat_cnt_after", 32'(beat_cnt), 32'd3);

        // Counter wrap: 17 beats with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) load(32'hE000_0000 + 32'(i));
        m_ready = 1'b1;
        saw_wrap = 1'b0; saw_one = 1'b0;
        prev_cnt = beat_cnt;
        repeat (25) begin
            sample();
            if (prev_cnt == 4'd15 && beat_cnt == 4'd0) saw_wrap = 1'b1;
            if (saw_wrap && prev_cnt == 4'd0 && beat_cnt == 4'd1) saw_one = 1'b1;
            prev_cnt = beat_cnt;
        end
        check("wrap_15_to_0", 32'(saw_wrap), 32'd1);
        check("wrap_0_to_1", 32'(saw_one), 32'd1);
        check("wrap_final_cnt", 32'(beat_cnt), 32'd1);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drainer for the asynchronous FIFO: runs entirely in the read clock domain, pops words via the FIFO's `rden`/`rdata`/`rempty` port and re-presents them as a valid/ready stream to downstream logic. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so throughput is one word per cycle while the FIFO is non-empty and the consumer is ready. It is the counterpart to the write-side producer that drives `wren`/`wdata`/`wfull`.

## Interface
- `DATA_W`, 32, width of FIFO read data and stream data.
- `CNT_W`, 16, width of the delivered-beat counter.
- `rclk`  in  1  read-domain clock; all logic on its rising edge.
- `rrst_n`  in  1  reset, asynchronous assert, active-low.
- `rempty`  in  1  FIFO empty flag (read domain).
- `rden`  out  1  FIFO read enable; one pop per cycle high.
- `rdata`  in  DATA_W  FIFO read data, valid the cycle after `rden`.
- `m_valid`  out  1  stream word available.
- `m_data`  out  DATA_W  stream word.
- `m_ready`  in  1  consumer accepts when `m_valid & m_ready`.
- `beat_cnt`  out  CNT_W  count of accepted stream beats, wraps modulo 2^CNT_W.

## Operation
- State: `occ` (0..2 buffered words), `inflight` (1 bit, registered copy of `rden`), 2-entry buffer with head/tail pointers, `beat_cnt`.
- `deq = m_valid & m_ready`; `m_valid = (occ != 0)`; `m_data` = buffer head.
- `rden = rrst_n & ~rempty & ((occ + inflight - deq) <= 1)`. Combinational from registered state, `rempty`, and `m_ready`.
- Never asserts `rden` while `rempty = 1`. Never has more than 2 words outstanding (buffered + in flight).
- Each edge: `inflight <= rden`. If `inflight`, write `rdata` at tail and advance tail. If `deq`, advance head and increment `beat_cnt`.
- `occ_next = occ + inflight - deq`; simultaneous capture and dequeue leaves `occ` unchanged. The write and read paths never touch the same entry, because `occ <= 1` whenever a capture coincides with `occ` at the limit.
- Buffer pointers are 1 bit and wrap naturally.
- Order preserved: stream order equals FIFO pop order.

## Timing
- Reset (`rrst_n` low, asynchronous): `occ = 0`, `inflight = 0`, pointers = 0, `beat_cnt = 0`. Outputs are then `m_valid = 0`, `rden = 0`, and `m_data` holds the buffer contents, which are don't-care and not reset.
- Reset mid-operation: any in-flight read is discarded, because its `rdata` is not captured. Buffered words are lost.
- First-word latency: `rempty` low in cycle 0 gives `rden` high in cycle 0. `rdata` is presented in cycle 1 and captured at the end of cycle 1. `m_valid` is high in cycle 2.
- Streaming: with `rempty = 0` and `m_ready = 1` held, `rden` stays high every cycle and `m_valid` stays high every cycle from cycle 2 on, with no bubbles.
- Backpressure: while `m_valid & ~m_ready`, `m_data` is stable and `m_valid` stays high. `rden` stops once `occ + inflight = 2`.
- Release after backpressure: `m_ready` high with `occ = 2` gives `deq` that cycle. `rden` may assert in the same cycle, since `2 + 0 - 1 <= 1`.
- `rempty` rising while `inflight = 1`: the in-flight word is still captured on the next edge. `rden` drops in the same cycle `rempty` rises.
- `beat_cnt` updates on the edge after an accepted beat, and wraps from 2^CNT_W-1 to 0.

## Test plan
- **Single word:** preload FIFO with 0xA5A5_0001, `m_ready = 1`.
  - `rden` pulses once.
  - `m_valid` is high for exactly one cycle, 2 cycles after `rempty` falls, with `m_data = 0xA5A5_0001`.
  - `beat_cnt = 1`.
- **Streaming:** preload 8 words 0..7, `m_ready = 1`.
  - 8 consecutive `m_valid` cycles carrying 0..7 in order.
  - `rden` high for exactly 8 cycles.
  - `beat_cnt = 8`.
- **Backpressure:** preload 5 words, hold `m_ready = 0` for 10 cycles, then release.
  - `rden` totals exactly 2 pops while stalled.
  - `m_data = word0`, stable throughout the stall.
  - After release, words 0..4 emerge in order with no gaps.
- **Empty guard:** random `m_ready` with the FIFO emptying mid-stream.
  - `rden & rempty` is never true.
  - No word is duplicated or dropped (scoreboard).
- **Reset mid-stream:** assert `rrst_n` low in the cycle after `rden`.
  - Immediately `m_valid = 0`, `rden = 0`, `beat_cnt = 0`.
  - After release, only the remaining FIFO words are delivered; the in-flight word is discarded.
- **Counter wrap:** with `CNT_W = 4`, stream 17 words.
  - `beat_cnt` reads 15, then 0, then 1.
